reg_file_master: RTL

//   Bus-side initiator for the 16x16 Register_File: accepts write/read burst commands on a

---
 rtl/reg_file_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/reg_file_master.sv
// rtl/reg_file_master.sv - burst command initiator driving a simple register file
module reg_file_master #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int LEN_WIDTH  = 4,
   parameter int RD_LATENCY = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic                  rdata_valid,
   input  logic                  rdata_ready,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  rdata_last,
   output logic                  done,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0] WrData,
   input  logic [DATA_WIDTH-1:0] RdData
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR       = 3'd1;
   localparam logic [2:0] RD_ISSUE = 3'd2;
   localparam logic [2:0] RD_WAIT  = 3'd3;
   localparam logic [2:0] RD_RESP  = 3'd4;
   localparam logic [2:0] DONE     = 3'd5;

   localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   logic [2:0]            state_q, state_d;
   logic                  cmd_ready_q, cmd_ready_d;
   logic                  wdata_ready_q, wdata_ready_d;
   logic                  rdata_valid_q, rdata_valid_d;
   logic                  rdata_last_q, rdata_last_d;
   logic                  done_q, done_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
   logic [LEN_WIDTH-1:0]  beats_q, beats_d;
   logic [WAIT_W-1:0]     wait_q, wait_d;

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      wdata_ready_d = wdata_ready_q;
      rdata_valid_d = rdata_valid_q;
      rdata_last_d  = rdata_last_q;
      done_d        = 1'b0;
      wr_en_d       = 1'b0;
      rd_en_d       = 1'b0;
      address_d     = address_q;
      wr_data_d     = wr_data_q;
      rdata_d       = rdata_q;
      addr_cnt_d    = addr_cnt_q;
      beats_d       = beats_q;
      wait_d        = wait_q;

      case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               beats_d     = cmd_len;
               if (cmd_write) begin
                  state_d       = WR;
                  wdata_ready_d = 1'b1;
                  addr_cnt_d    = cmd_addr;
               end else begin
                  // First read is issued directly from the accept edge.
                  state_d    = RD_ISSUE;
                  rd_en_d    = 1'b1;
                  address_d  = cmd_addr;
                  addr_cnt_d = cmd_addr + ADDR_WIDTH'(1);
               end
            end
         end
         WR: begin
            // wdata_ready drops after the last beat so the final WrEn cycle stays in WR.
            if (wdata_ready_q) begin
               if (wdata_valid) begin
                  wr_en_d    = 1'b1;
                  address_d  = addr_cnt_q;
                  wr_data_d  = wdata;
                  addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                  if (beats_q == '0) begin
                     wdata_ready_d = 1'b0;
                  end else begin
                     beats_d = beats_q - LEN_WIDTH'(1);
                  end
               end
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         RD_ISSUE: begin
            state_d = RD_WAIT;
            wait_d  = WAIT_W'(RD_LATENCY - 1);
         end
         RD_WAIT: begin
            if (wait_q == '0) begin
               state_d       = RD_RESP;
               rdata_d       = RdData;
               rdata_valid_d = 1'b1;
               rdata_last_d  = (beats_q == '0);
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         RD_RESP: begin
            if (rdata_ready) begin
               rdata_valid_d = 1'b0;
               rdata_last_d  = 1'b0;
               if (beats_q == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  beats_d    = beats_q - LEN_WIDTH'(1);
                  state_d    = RD_ISSUE;
                  rd_en_d    = 1'b1;
                  address_d  = addr_cnt_q;
                  addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
               end
            end
         end
         DONE: begin
            state_d     = IDLE;
            cmd_ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         wdata_ready_q <= 1'b0;
         rdata_valid_q <= 1'b0;
         rdata_last_q  <= 1'b0;
         done_q        <= 1'b0;
         wr_en_q       <= 1'b0;
         rd_en_q       <= 1'b0;
         address_q     <= '0;
         wr_data_q     <= '0;
         rdata_q       <= '0;
         addr_cnt_q    <= '0;
         beats_q       <= '0;
         wait_q        <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         wdata_ready_q <= wdata_ready_d;
         rdata_valid_q <= rdata_valid_d;
         rdata_last_q  <= rdata_last_d;
         done_q        <= done_d;
         wr_en_q       <= wr_en_d;
         rd_en_q       <= rd_en_d;
         address_q     <= address_d;
         wr_data_q     <= wr_data_d;
         rdata_q       <= rdata_d;
         addr_cnt_q    <= addr_cnt_d;
         beats_q       <= beats_d;
         wait_q        <= wait_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign wdata_ready = wdata_ready_q;
   assign rdata_valid = rdata_valid_q;
   assign rdata_last  = rdata_last_q;
   assign rdata       = rdata_q;
   assign done        = done_q;
   assign WrEn        = wr_en_q;
   assign RdEn        = rd_en_q;
   assign Address     = address_q;
   assign WrData      = wr_data_q;

endmodule
